// File: rtl/mdu_defs.sv
// mdu_defs: op and FSM encodings, divide-by-zero constant and negation helpers shared by mdu_iter.
package mdu_defs;
    localparam int XLEN = 32;
    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;
    localparam logic [XLEN-1:0] DIV0_LO = 32'hFFFF_FFFF;

    function automatic logic [XLEN-1:0] neg32(input logic [XLEN-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    function automatic logic [2*XLEN-1:0] neg64(input logic [2*XLEN-1:0] v, input logic n);
        return n ? -v : v;
    endfunction
endpackage

// File: rtl/mdu_abs_sign.sv
// mdu_abs_sign: operand magnitudes plus result/remainder sign flags for signed MULT/DIV.
module mdu_abs_sign
    import mdu_defs::*;
(
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic [XLEN-1:0] mag_a,
    output logic [XLEN-1:0] mag_b,
    output logic            neg_res,
    output logic            neg_rem
);
    logic sa, sb;

    always_comb begin
        sa      = ~op[0] & src_a[XLEN-1];
        sb      = ~op[0] & src_b[XLEN-1];
        mag_a   = neg32(src_a, sa);
        mag_b   = neg32(src_b, sb);
        neg_res = sa ^ sb;
        neg_rem = sa;
    end
endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO writes.
// Define MDU_FAST_MUL_EN for a single-cycle multiply path; divide stays iterative.
module mdu_iter
    import mdu_defs::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    logic [1:0]         state, op_r;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc, raw, res, step;
    logic [WIDTH-1:0]   opb, mag_a, mag_b, rem;
    logic [WIDTH:0]     sum, sh;
    logic               neg_res, neg_rem, nr_in, nm_in, is_div, ge;

    mdu_abs_sign u_abs (
        .op(op), .src_a(src_a), .src_b(src_b),
        .mag_a(mag_a), .mag_b(mag_b), .neg_res(nr_in), .neg_rem(nm_in)
    );

    // acc is the shift-add product for multiply, {remainder, dividend/quotient} for divide
    always_comb begin
        is_div = op_r[1];
        sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
        sh     = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        ge     = sh >= {1'b0, opb};
        rem    = ge ? sh[WIDTH-1:0] - opb : sh[WIDTH-1:0];
        step   = is_div ? {rem, acc[WIDTH-2:0], ge} : {sum, acc[WIDTH-1:1]};
`ifdef MDU_FAST_MUL_EN
        raw    = is_div ? acc : {{WIDTH{1'b0}}, opb} * {{WIDTH{1'b0}}, acc[WIDTH-1:0]};
`else
        raw    = acc;
`endif
        res    = is_div ? {neg32(raw[2*WIDTH-1:WIDTH], neg_rem),
                           (opb == '0) ? DIV0_LO : neg32(raw[WIDTH-1:0], neg_res)}
                        : neg64(raw, neg_res);
        busy   = (state == S_CALC) || (state == S_FIX);
        done   = state == S_DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            op_r    <= '0;
            cnt     <= '0;
            acc     <= '0;
            opb     <= '0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                    if (start) begin
                        state   <= S_CALC;
                        op_r    <= op;
                        cnt     <= '0;
                        neg_res <= nr_in;
                        neg_rem <= nm_in;
                        acc     <= {{WIDTH{1'b0}}, op[1] ? mag_a : mag_b};
                        opb     <= op[1] ? mag_b : mag_a;
                    end
                end
                S_CALC: begin
                    acc <= step;
                    cnt <= cnt + 1'b1;
`ifdef MDU_FAST_MUL_EN
                    if (!is_div) begin
                        {hi, lo} <= res;
                        state    <= S_DONE;
                    end else
`endif
                    if (cnt == CNT_W'(WIDTH - 1)) state <= S_FIX;
                end
                S_FIX: begin
                    {hi, lo} <= res;
                    state    <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: directed table, random ops against an arithmetic model, and multi-cycle corner sequences.
module tb_mdu_iter;
    logic        clk = 0, rst_n = 0, start = 0, hi_we = 0, lo_we = 0;
    logic [1:0]  op = 0;
    logic [31:0] src_a = 0, src_b = 0, wdata = 0;
    logic        busy, done;
    logic [31:0] hi, lo;
    int          checks = 0, errors = 0;

`ifdef MDU_FAST_MUL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    typedef struct {
        logic [1:0]  o;
        logic [31:0] a, b, hi, lo;
    } vec_t;

    always #5 clk = ~clk;

    mdu_iter dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        int          sa, sb;
        longint      p;
        logic [63:0] r;
        sa = a;
        sb = b;
        case (o)
            2'b00: begin
                p = longint'(sa) * longint'(sb);
                r = p;
            end
            2'b01: r = {32'b0, a} * {32'b0, b};
            2'b10: begin
                if (b == 0) r = {a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'h0, 32'h8000_0000};
                else r = {32'(sa % sb), 32'(sa / sb)};
            end
            default: r = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
        endcase
        return r;
    endfunction

    function automatic int exp_lat(input logic [1:0] o);
        return (FAST && !o[1]) ? 1 : 33;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int intr, input bit poke_done, output logic [31:0] rhi, output logic [31:0] rlo);
        int lat;
        @(negedge clk);
        op = o; src_a = a; src_b = b; start = 1;
        @(posedge clk);
        #1 start = 0;
        chk({name, " busy after accept"}, busy, 1);
        lat = 0;
        while (!done && lat < 100) begin
            @(posedge clk);
            #1 lat++;
            if (lat == intr) begin
                start = 1; hi_we = 1; lo_we = 1; wdata = 32'hDEAD_BEEF;
                op = 2'b11; src_a = 32'd1; src_b = 32'd1;
            end else begin
                start = 0; hi_we = 0; lo_we = 0;
            end
        end
        chk({name, " latency"}, lat, exp_lat(o));
        chk({name, " busy at done"}, busy, 0);
        rhi = hi;
        rlo = lo;
        start = poke_done; hi_we = 0; lo_we = 0;
        @(posedge clk);
        #1 start = 0;
        if (poke_done) chk({name, " start in DONE ignored"}, busy, 0);
    endtask

    initial begin
        vec_t        tv[9];
        logic [31:0] rh, rl, a, b;
        logic [1:0]  o;
        logic [63:0] e;
        tv[0] = '{2'b00, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        tv[1] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        tv[2] = '{2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        tv[3] = '{2'b11, 32'd100, 32'd7, 32'd2, 32'd14};
        tv[4] = '{2'b11, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF};
        tv[5] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000};
        tv[6] = '{2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD};
        tv[7] = '{2'b10, 32'hFFFF_FFF8, 32'd0, 32'hFFFF_FFF8, 32'hFFFF_FFFF};
        tv[8] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0};

        #12;
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset hi", hi, 0);
        chk("reset lo", lo, 0);
        @(negedge clk) rst_n = 1;

        @(negedge clk);
        hi_we = 1; wdata = 32'hA5A5_A5A5;
        @(posedge clk);
        #1 hi_we = 0;
        chk("mthi hi", hi, 32'hA5A5_A5A5);
        chk("mthi lo untouched", lo, 0);
        @(negedge clk);
        lo_we = 1; wdata = 32'h5A5A_1234;
        @(posedge clk);
        #1 lo_we = 0;
        chk("mtlo lo", lo, 32'h5A5A_1234);

        for (int i = 0; i < 9; i++) begin
            run_op($sformatf("vec%0d", i), tv[i].o, tv[i].a, tv[i].b, 0, i == 0, rh, rl);
            chk($sformatf("vec%0d hi", i), rh, tv[i].hi);
            chk($sformatf("vec%0d lo", i), rl, tv[i].lo);
        end

        o = FAST ? 2'b10 : 2'b00;
        e = model(o, 32'd7, 32'hFFFF_FFFD);
        run_op("ignore busy", o, 32'd7, 32'hFFFF_FFFD, 10, 1'b0, rh, rl);
        chk("ignore busy hi", rh, e[63:32]);
        chk("ignore busy lo", rl, e[31:0]);
        @(posedge clk);
        #1 chk("ignored start not queued", busy, 0);

        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom_range(0, 3));
            a = pick();
            b = pick();
            e = model(o, a, b);
            run_op($sformatf("rnd%0d op%0d %h %h", i, o, a, b), o, a, b, 0, 1'b0, rh, rl);
            chk($sformatf("rnd%0d hi", i), rh, e[63:32]);
            chk($sformatf("rnd%0d lo", i), rl, e[31:0]);
        end

        @(negedge clk);
        op = 2'b11; src_a = 32'd100; src_b = 32'd7; start = 1; lo_we = 1; wdata = 32'h0000_1234;
        @(posedge clk);
        #1 start = 0; lo_we = 0;
        repeat (14) @(posedge clk);
        #1 chk("coincident write lo", lo, 32'h0000_1234);
        chk("mid-op busy", busy, 1);
        #1 rst_n = 0;
        #1;
        chk("async reset busy", busy, 0);
        chk("async reset done", done, 0);
        chk("async reset hi", hi, 0);
        chk("async reset lo", lo, 0);
        @(negedge clk) rst_n = 1;
        run_op("after reset", 2'b11, 32'd100, 32'd7, 0, 1'b0, rh, rl);
        chk("after reset hi", rh, 32'd2);
        chk("after reset lo", rl, 32'd14);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
endmodule
